exunit_mul_pipe: RTL
====================

# exunit_mul_pipe

Parametrised, fully pipelined integer multiply execution unit for the out-of-order core. It sits between the multiply reservation station and the ROB/RRF writeback.

- Accepts one multiply per cycle and tracks up to `MUL_STAGES` in-flight operations.
- Each operation carries its own RRF tag and speculation tag.
- In-flight operations are squashed individually on branch mispredict, and their spec bits are cleared on a correct prediction.
- Optional zero-operand early-out completes an operation in 1 cycle when the writeback slot is free.

## Interface
- `DATA_LEN`, 32: operand/result width.
- `RRF_TAG_LEN`, 6: rename-register tag width.
- `SPECTAG_LEN`, 5: one-hot speculation tag width.
- `MUL_STAGES`, 4: pipeline depth and full latency; legal range 2..7.
- `EARLY_OUT`, 1: 1 enables the zero-operand early-out; 0 gives constant latency.
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `issue` in 1: operation valid this cycle; always accepted.
- `ex_src1`, `ex_src2` in `DATA_LEN`: operands.
- `src1_signed`, `src2_signed` in 1: operand signedness.
- `sel_lohi` in 1: 0 selects the low half of the 2×`DATA_LEN` product, 1 the high half.
- `dstval` in 1: operation writes the RRF.
- `rrftag` in `RRF_TAG_LEN`: destination tag.
- `specbit` in 1: operation is speculative.
- `spectag` in `SPECTAG_LEN`: its branch tag.
- `prmiss`, `prsuccess` in 1: branch resolved mispredicted / correct.
- `spectagfix` in `SPECTAG_LEN`: tag of the resolved branch.
- `result` out `DATA_LEN`: writeback data.
- `wb_rrftag` out `RRF_TAG_LEN`: writeback tag.
- `rob_we` out 1: operation finished (ROB finish bit).
- `rrf_we` out 1: RRF write; equals `rob_we & dstval` of the finishing entry.
- `inflight` out 3: number of valid entries, 0..`MUL_STAGES`.

## Operation
**Pipeline entries**
- There is one entry per stage, k = 1..`MUL_STAGES`.
- Each entry holds: valid, product (already lo/hi selected), dstval, rrftag, specbit, spectag, zero flag.
- On issue, stage 1 is written at the next edge. The product is computed combinationally from the issue-cycle operands.
- Entries advance one stage per cycle unconditionally; there is no stall.

**Kill**
- An entry is killed when `prmiss && specbit && (spectag & spectagfix) != 0`.
- A killed entry's valid is cleared at the edge.
- The same test applies to the incoming issue; a killed issue never enters stage 1.
- A killed entry in the writeback position suppresses `rob_we`/`rrf_we` combinationally in that same cycle.

**Spec clear**
- On `prsuccess`, entries with `(spectag & spectagfix) != 0` clear specbit at the edge.
- This also applies to the entry being written into stage 1.
- `prmiss` and `prsuccess` are never both high; if both are high, `prmiss` wins.

**Writeback selection**
- The stage-`MUL_STAGES` entry, if valid and not killed, writes back and leaves the pipe.
- Otherwise, if `EARLY_OUT=1` and the stage-1 entry is valid, not killed, and has its zero flag set, stage 1 writes back. That entry's valid is dropped instead of advancing.
- The zero flag is set when either operand equals 0.
- At most one writeback per cycle. The tail entry always has priority; a zero-operand entry that loses arbitration continues at full latency.

**Arithmetic**
- The product is a 2×`DATA_LEN` signed/unsigned mix, matching RISC-V MUL/MULH/MULHSU/MULHU.
- A zero operand always yields a result of 0.

**Outputs**
- `result`/`wb_rrftag` are 0 when `rob_we=0`.

## Timing
- Issue is sampled at edge t.
- Full-latency writeback: `rob_we` is high during cycle t+`MUL_STAGES`.
- Early-out writeback: `rob_we` is high during cycle t+1.
- Throughput is 1 operation per cycle.
- `inflight` is registered and reflects the entries after the edge.
- Reset: all valids 0. `rob_we`, `rrf_we`, `result`, `wb_rrftag` and `inflight` are all 0 in the first cycle after reset. Reset mid-operation discards all entries with no writeback.

## Structure
- Shared constants package holds `DATA_LEN`, `RRF_TAG_LEN`, `SPECTAG_LEN`, the default `MUL_STAGES`, and the entry record layout.
- Sub-module `mul_signed_core`: combinational 2×`DATA_LEN` product with lo/hi select.
- Top level: entry array, kill/clear logic, writeback mux, occupancy counter.

## Test plan
- Back-to-back issue of 5×7, -3×4 (signed), 0xFFFFFFFF×2 (MULHU), `MUL_STAGES=4` -> `rob_we` in cycles t+4, t+5, t+6 with results 35, 0xFFFFFFF4, 1; `inflight` peaks at 3.
- `EARLY_OUT=1`, issue 0×9 into an empty pipe -> `rob_we` at t+1, result 0. Repeat with a tail entry arriving in the same cycle -> the tail writes back first and the zero op completes at t+4.
- `EARLY_OUT=0`, issue 0×9 -> `rob_we` at t+4, never earlier.
- Issue three ops with spectags 00001, 00010, 00001 (specbit=1). Pulse `prmiss` with `spectagfix`=00001 while they are in stages 1–3 -> only the 00010 op writes back; `inflight` drops to 1.
- `prsuccess` with `spectagfix`=00010 on an in-flight op, then `prmiss` with the same tag -> the op still writes back.
- Assert reset with 3 ops in flight -> no `rob_we` afterwards, `inflight`=0, all outputs 0.

Source files
------------

// File: rtl/exunit_mul_pipe_pkg.sv
// Shared constants, pipeline entry layout and speculation helper for the
// pipelined multiply execution unit.
package exunit_mul_pipe_pkg;

    localparam int MUL_DATA_LEN    = 32;
    localparam int MUL_RRF_TAG_LEN = 6;
    localparam int MUL_SPECTAG_LEN = 5;
    localparam int MUL_STAGES_DEF  = 4;

    // Product is stored already lo/hi selected so writeback is a plain mux.
    typedef struct packed {
        logic                       valid;
        logic [MUL_DATA_LEN-1:0]    product;
        logic                       dstval;
        logic [MUL_RRF_TAG_LEN-1:0] rrftag;
        logic                       specbit;
        logic [MUL_SPECTAG_LEN-1:0] spectag;
        logic                       zero;
    } mul_entry_t;

    function automatic logic tag_hit(input logic [MUL_SPECTAG_LEN-1:0] tag,
                                     input logic [MUL_SPECTAG_LEN-1:0] fix);
        return |(tag & fix);
    endfunction

endpackage

// File: rtl/exunit_mul_pipe_mul_signed_core.sv
// Combinational DATA_LEN x DATA_LEN multiplier with per-operand signedness
// and selection of the low or high half of the double-width product.
module mul_signed_core
    import exunit_mul_pipe_pkg::*;
#(
    parameter int DATA_LEN = MUL_DATA_LEN
) (
    input  logic [DATA_LEN-1:0] src1,
    input  logic [DATA_LEN-1:0] src2,
    input  logic                src1_signed,
    input  logic                src2_signed,
    input  logic                sel_hi,
    output logic [DATA_LEN-1:0] product
);

    logic [2*DATA_LEN-1:0] ext1;
    logic [2*DATA_LEN-1:0] ext2;
    logic [2*DATA_LEN-1:0] full;

    // Extending both operands to double width makes one truncated multiply
    // cover MUL, MULH, MULHSU and MULHU.
    always_comb begin
        ext1    = {{DATA_LEN{src1_signed & src1[DATA_LEN-1]}}, src1};
        ext2    = {{DATA_LEN{src2_signed & src2[DATA_LEN-1]}}, src2};
        full    = ext1 * ext2;
        product = sel_hi ? full[2*DATA_LEN-1:DATA_LEN] : full[DATA_LEN-1:0];
    end

endmodule

// File: rtl/exunit_mul_pipe.sv
// Fully pipelined multiply execution unit: per-entry squash/clear on branch
// resolution, optional zero-operand early-out, and an occupancy counter.
module exunit_mul_pipe
    import exunit_mul_pipe_pkg::*;
#(
    parameter int DATA_LEN    = MUL_DATA_LEN,
    parameter int RRF_TAG_LEN = MUL_RRF_TAG_LEN,
    parameter int SPECTAG_LEN = MUL_SPECTAG_LEN,
    parameter int MUL_STAGES  = MUL_STAGES_DEF,
    parameter int EARLY_OUT   = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   issue,
    input  logic [DATA_LEN-1:0]    ex_src1,
    input  logic [DATA_LEN-1:0]    ex_src2,
    input  logic                   src1_signed,
    input  logic                   src2_signed,
    input  logic                   sel_lohi,
    input  logic                   dstval,
    input  logic [RRF_TAG_LEN-1:0] rrftag,
    input  logic                   specbit,
    input  logic [SPECTAG_LEN-1:0] spectag,
    input  logic                   prmiss,
    input  logic                   prsuccess,
    input  logic [SPECTAG_LEN-1:0] spectagfix,
    output logic [DATA_LEN-1:0]    result,
    output logic [RRF_TAG_LEN-1:0] wb_rrftag,
    output logic                   rob_we,
    output logic                   rrf_we,
    output logic [2:0]             inflight
);

    mul_entry_t            pipe_q [1:MUL_STAGES];
    mul_entry_t            pipe_d [1:MUL_STAGES];
    mul_entry_t            issue_entry;
    mul_entry_t            wb_entry;
    logic [DATA_LEN-1:0]   issue_product;
    logic [2:0]            inflight_q;
    logic [2:0]            inflight_d;
    logic                  tail_wb;
    logic                  early_wb;

    function automatic logic killed(input mul_entry_t e, input logic miss,
                                    input logic [SPECTAG_LEN-1:0] fix);
        return miss && e.specbit && tag_hit(e.spectag, fix);
    endfunction

    // A mispredict outranks a simultaneous correct-prediction pulse.
    function automatic mul_entry_t resolve(input mul_entry_t e, input logic miss,
                                           input logic succ,
                                           input logic [SPECTAG_LEN-1:0] fix);
        mul_entry_t r;
        r = e;
        if (killed(e, miss, fix)) begin
            r.valid = 1'b0;
        end else if (succ && tag_hit(e.spectag, fix)) begin
            r.specbit = 1'b0;
        end
        return r;
    endfunction

    mul_signed_core #(
        .DATA_LEN(DATA_LEN)
    ) u_core (
        .src1       (ex_src1),
        .src2       (ex_src2),
        .src1_signed(src1_signed),
        .src2_signed(src2_signed),
        .sel_hi     (sel_lohi),
        .product    (issue_product)
    );

    always_comb begin
        issue_entry         = '0;
        issue_entry.valid   = issue;
        issue_entry.product = issue_product;
        issue_entry.dstval  = dstval;
        issue_entry.rrftag  = rrftag;
        issue_entry.specbit = specbit;
        issue_entry.spectag = spectag;
        issue_entry.zero    = (ex_src1 == '0) || (ex_src2 == '0);
    end

    // The tail always wins; a zero-operand head only uses an idle slot.
    always_comb begin
        tail_wb   = pipe_q[MUL_STAGES].valid && !killed(pipe_q[MUL_STAGES], prmiss, spectagfix);
        early_wb  = (EARLY_OUT != 0) && !tail_wb && pipe_q[1].valid && pipe_q[1].zero &&
                    !killed(pipe_q[1], prmiss, spectagfix);
        wb_entry  = tail_wb ? pipe_q[MUL_STAGES] : pipe_q[1];
        rob_we    = tail_wb || early_wb;
        rrf_we    = rob_we && wb_entry.dstval;
        result    = rob_we ? wb_entry.product : '0;
        wb_rrftag = rob_we ? wb_entry.rrftag : '0;
    end

    always_comb begin
        pipe_d[1] = resolve(issue_entry, prmiss, prsuccess, spectagfix);
        for (int k = 2; k <= MUL_STAGES; k++) begin
            pipe_d[k] = resolve(pipe_q[k-1], prmiss, prsuccess, spectagfix);
        end
        if (early_wb) begin
            pipe_d[2].valid = 1'b0;
        end
        inflight_d = '0;
        for (int k = 1; k <= MUL_STAGES; k++) begin
            inflight_d = inflight_d + {2'b00, pipe_d[k].valid};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 1; k <= MUL_STAGES; k++) begin
                pipe_q[k] <= '0;
            end
            inflight_q <= '0;
        end else begin
            for (int k = 1; k <= MUL_STAGES; k++) begin
                pipe_q[k] <= pipe_d[k];
            end
            inflight_q <= inflight_d;
        end
    end

    assign inflight = inflight_q;

endmodule
